seq_cu: RTL and testbench

SEQ_CU -- requirements
Module: seq_cu

---
 rtl/cu_pkg.sv | 23 ++
 rtl/cu_decode.sv | 28 ++
 rtl/seq_cu.sv | 135 +++++++++++++
 tb/tb_seq_cu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the sequencer control unit: state encoding and opcodes.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMOP  = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam int OP_CLA = 0;
  localparam int OP_COM = 1;
  localparam int OP_SHR = 2;
  localparam int OP_CSL = 3;
  localparam int OP_STP = 4;
  localparam int OP_ADD = 5;
  localparam int OP_STA = 6;
  localparam int OP_LDA = 7;
  localparam int OP_JMP = 8;
  localparam int OP_BAN = 9;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier for the sequencer control unit.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] op,
  output logic            is_reg,
  output logic            is_rd,
  output logic            is_wr,
  output logic            is_jmp,
  output logic            is_ban,
  output logic            is_stop,
  output logic            is_ill
);

  // Classify the opcode; everything above the highest defined opcode is illegal.
  always_comb begin
    is_reg  = (op <= OP_W'(OP_CSL));
    is_rd   = (op == OP_W'(OP_ADD)) || (op == OP_W'(OP_LDA));
    is_wr   = (op == OP_W'(OP_STA));
    is_jmp  = (op == OP_W'(OP_JMP));
    is_ban  = (op == OP_W'(OP_BAN));
    is_stop = (op == OP_W'(OP_STP));
    is_ill  = (op >  OP_W'(OP_BAN));
  end

endmodule

// File: rtl/seq_cu.sv
// Multi-cycle sequencer control unit: fetch / decode / execute / memory-op / halt.
module seq_cu
  import cu_pkg::*;
#(
  parameter int OP_W   = 7,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   resume,
  input  logic [OP_W+ADDR_W-1:0] mem_rdata,
  input  logic                   mem_ready,
  input  logic                   acc_neg,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic                   acc_wr_en,
  output logic [OP_W-1:0]        alu_op,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halted,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired
);

  localparam int IR_W = OP_W + ADDR_W;

  state_t            state;
  state_t            next_state;
  logic [IR_W-1:0]   ir;
  logic [OP_W-1:0]   ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic              is_reg, is_rd, is_wr, is_jmp, is_ban, is_stop, is_ill;
  logic              retire_now;

  assign ir_op   = ir[IR_W-1 -: OP_W];
  assign ir_addr = ir[ADDR_W-1:0];

  cu_decode #(.OP_W(OP_W)) u_decode (
    .op      (ir_op),
    .is_reg  (is_reg),
    .is_rd   (is_rd),
    .is_wr   (is_wr),
    .is_jmp  (is_jmp),
    .is_ban  (is_ban),
    .is_stop (is_stop),
    .is_ill  (is_ill)
  );

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An instruction completes when EXEC finishes without a memory phase (illegal
  // opcodes never complete), or when its memory operation is acknowledged.
  assign retire_now = ((state == EXEC) && !is_ill && !is_rd && !is_wr) ||
                      ((state == MEMOP) && mem_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    unique case (state)
      FETCH:   if (mem_ready) next_state = DECODE;
      DECODE:  next_state = EXEC;
      EXEC: begin
        if (is_ill || is_stop)    next_state = HALT;
        else if (is_rd || is_wr)  next_state = MEMOP;
        else                      next_state = FETCH;
      end
      MEMOP:   if (mem_ready) next_state = FETCH;
      HALT:    if (resume && !illegal) next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Program counter, instruction register, sticky illegal flag and retire count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if ((state == FETCH) && mem_ready) begin
        ir <= mem_rdata;
        pc <= pc + 1'b1;
      end
      if (state == EXEC) begin
        if (is_jmp || (is_ban && acc_neg)) pc <= ir_addr;
        if (is_ill) illegal <= 1'b1;
      end
      if (retire_now) retired <= sat_inc(retired);
    end
  end

  // Strobes and status; gated by rst_n so nothing is driven while reset is held.
  always_comb begin
    mem_addr  = pc;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    acc_wr_en = 1'b0;
    alu_op    = '0;
    halted    = 1'b0;
    if (rst_n) begin
      unique case (state)
        FETCH: mem_rd = 1'b1;
        EXEC: begin
          if (is_reg) begin
            acc_wr_en = 1'b1;
            alu_op    = ir_op;
          end
        end
        MEMOP: begin
          mem_addr = ir_addr;
          mem_rd   = is_rd;
          mem_wr   = is_wr;
          if (is_rd && mem_ready) begin
            acc_wr_en = 1'b1;
            alu_op    = ir_op;
          end
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cu.sv
// Directed-vector bench for seq_cu with a small memory and accumulator model.
module tb_seq_cu;
  import cu_pkg::*;

  localparam int OP_W   = 7;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;
  localparam int W      = OP_W + ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              resume = 1'b0;
  logic              acc_neg = 1'b0;
  logic              stall = 1'b0;
  logic [W-1:0]      mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr, acc_wr_en, halted, illegal;
  logic [OP_W-1:0]   alu_op;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  retired;

  logic [W-1:0]      mem [256];
  logic [W-1:0]      acc;
  logic [ADDR_W-1:0] st_addr;
  logic [W-1:0]      st_data;
  int                st_cnt = 0;
  int                checks = 0;
  int                failures = 0;

  seq_cu #(.OP_W(OP_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .resume    (resume),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .acc_neg   (acc_neg),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .acc_wr_en (acc_wr_en),
    .alu_op    (alu_op),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Memory answers immediately unless the bench is stalling it.
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (mem_rd || mem_wr) && !stall;

  // Accumulator model driven by the control unit's write enable.
  always @(posedge clk) begin
    if (acc_wr_en) begin
      case (int'(alu_op))
        OP_CLA:  acc <= '0;
        OP_COM:  acc <= ~acc;
        OP_SHR:  acc <= acc >> 1;
        OP_CSL:  acc <= {acc[W-2:0], acc[W-1]};
        OP_ADD:  acc <= acc + mem_rdata;
        OP_LDA:  acc <= mem_rdata;
        default: acc <= acc;
      endcase
    end
  end

  // Record completed stores.
  always @(posedge clk) begin
    if (mem_wr && mem_ready) begin
      st_addr <= mem_addr;
      st_data <= acc;
      st_cnt  <= st_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] w(input int op, input int a);
    logic [OP_W-1:0]   o;
    logic [ADDR_W-1:0] ad;
    o  = op[OP_W-1:0];
    ad = a[ADDR_W-1:0];
    return {o, ad};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = w(OP_STP, 0);
  endtask

  // Hold reset for two edges, optionally check the reset state, then release.
  task automatic reset_release(input bit do_chk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (do_chk) begin
      chk("rst_pc", pc, 0);
      chk("rst_retired", retired, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_strobes", {mem_rd, mem_wr, acc_wr_en}, 0);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic run_to_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    chk("halt_reached", halted, 1);
  endtask

  initial begin
    // Program: LDA 0x10; ADD 0x11; STA 0x12; STP
    clear_mem();
    mem[0] = w(OP_LDA, 8'h10);
    mem[1] = w(OP_ADD, 8'h11);
    mem[2] = w(OP_STA, 8'h12);
    mem[3] = w(OP_STP, 0);
    mem[8'h10] = 15'd3;
    mem[8'h11] = 15'd4;
    reset_release(1'b1);
    chk("first_fetch_rd", mem_rd, 1);
    chk("first_fetch_addr", mem_addr, 0);
    run_to_halt(100);
    chk("prog_st_addr", st_addr, 8'h12);
    chk("prog_st_data", st_data, 7);
    chk("prog_retired", retired, 4);
    chk("prog_pc", pc, 4);
    chk("prog_illegal", illegal, 0);
    repeat (3) @(negedge clk);
    chk("halt_quiet", {mem_rd, mem_wr, acc_wr_en}, 0);
    chk("halt_pc_frozen", pc, 4);
    // Resume runs the STP at address 4 and halts again.
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_left_halt", halted, 0);
    run_to_halt(50);
    chk("resume_retired", retired, 5);
    chk("resume_pc", pc, 5);

    // BAN taken and not taken.
    for (int n = 1; n >= 0; n--) begin
      clear_mem();
      mem[0] = w(OP_BAN, 8'h20);
      acc_neg = n[0];
      reset_release(1'b0);
      @(negedge clk);
      chk("decode_strobes", {mem_rd, mem_wr, acc_wr_en}, 0);
      chk("decode_alu_op", alu_op, 0);
      @(negedge clk);
      chk("ban_exec_no_wr", acc_wr_en, 0);
      @(negedge clk);
      chk(n ? "ban_taken_pc" : "ban_not_taken_pc", pc, n ? 8'h20 : 8'h01);
      chk("ban_next_fetch", {mem_rd, mem_addr}, {1'b1, (n ? 8'h20 : 8'h01)});
    end
    acc_neg = 1'b0;

    // Stalled FETCH and stalled STA MEMOP.
    clear_mem();
    mem[0] = w(OP_STA, 8'h30);
    stall = 1'b1;
    reset_release(1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_fetch", {mem_rd, mem_wr, mem_addr}, {2'b10, 8'h00});
      if (i < 4) @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_memop", {mem_rd, mem_wr, mem_addr}, {2'b01, 8'h30});
      if (i < 4) @(negedge clk);
    end
    stall = 1'b0;
    run_to_halt(50);
    chk("stall_st_addr", st_addr, 8'h30);
    chk("stall_retired", retired, 2);

    // Illegal opcode: sticky, resume ignored, cleared by reset.
    clear_mem();
    mem[0] = w(7'h7F, 0);
    reset_release(1'b0);
    run_to_halt(50);
    chk("ill_flag", illegal, 1);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    repeat (3) @(negedge clk);
    chk("ill_still_halted", halted, 1);
    chk("ill_no_fetch", mem_rd, 0);
    chk("ill_pc_frozen", pc, 1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ill_rst_clears", {illegal, halted}, 0);

    // JMP to the top address, then CLA wraps pc to 0.
    clear_mem();
    mem[0]     = w(OP_JMP, 8'hFF);
    mem[8'hFF] = w(OP_CLA, 0);
    reset_release(1'b0);
    repeat (3) @(negedge clk);
    chk("jmp_fetch_addr", mem_addr, 8'hFF);
    @(negedge clk);
    chk("wrap_pc", pc, 0);
    @(negedge clk);
    chk("cla_exec", {acc_wr_en, alu_op}, {1'b1, 7'd0});

    // Reset in the middle of a stalled STA.
    clear_mem();
    mem[0] = w(OP_STA, 8'h40);
    reset_release(1'b0);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("sta_memop_wr", {mem_wr, mem_addr}, {1'b1, 8'h40});
    begin
      int cnt0;
      cnt0 = st_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_wr_drop", {mem_rd, mem_wr}, 0);
      chk("rst_mid_pc", pc, 0);
      stall = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rst_mid_refetch", {mem_rd, mem_addr}, {1'b1, 8'h00});
      chk("rst_mid_no_store", st_cnt, cnt0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
